// File: rtl/uart_rx_oversample.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : uart_rx_oversample
// Brief   : 8N1 UART receiver, 2-of-3 mid-bit vote on an oversample strobe.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_oversample #(
  parameter int SAMPLE_MULTIPLIER = 8,
  parameter int CNT_WIDTH         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxclk_en,
  input  logic       rx,
  output logic [7:0] ucode,
  output logic       uvalid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_STOP  = 3'd3;
  localparam logic [2:0] c_BREAK = 3'd4;

  localparam logic [CNT_WIDTH-1:0] c_TC_S0   = CNT_WIDTH'(SAMPLE_MULTIPLIER/2 - 1);
  localparam logic [CNT_WIDTH-1:0] c_TC_S1   = CNT_WIDTH'(SAMPLE_MULTIPLIER/2);
  localparam logic [CNT_WIDTH-1:0] c_TC_VOTE = CNT_WIDTH'(SAMPLE_MULTIPLIER/2 + 1);
  localparam logic [CNT_WIDTH-1:0] c_TC_LAST = CNT_WIDTH'(SAMPLE_MULTIPLIER - 1);

  logic                 r_sync1, r_sync2;
  logic                 w_rx_s;
  logic [2:0]           r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_tc, w_tc_next;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic [1:0]           r_samp;
  logic [7:0]           r_ucode;
  logic                 r_uvalid, r_ferr;
  logic                 w_vote, w_at_vote, w_at_last, w_load, w_ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s    = r_sync2;
  assign w_vote    = (r_samp[0] & r_samp[1]) | (w_rx_s & (r_samp[0] | r_samp[1]));
  assign w_at_vote = (r_tc == c_TC_VOTE);
  assign w_at_last = (r_tc == c_TC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (rxclk_en) begin
      case (r_state)
        c_IDLE:  if (!w_rx_s) w_state_next = c_START;
        c_START: begin
          if (w_at_vote && w_vote) w_state_next = c_IDLE;
          else if (w_at_last)      w_state_next = c_DATA;
        end
        c_DATA:  if (w_at_last && (r_bit_idx == 3'd7)) w_state_next = c_STOP;
        c_STOP:  if (w_at_vote) w_state_next = w_vote ? c_IDLE : c_BREAK;
        c_BREAK: if (w_rx_s) w_state_next = c_IDLE;
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (r_state != c_IDLE);
    w_load = rxclk_en && (r_state == c_STOP) && w_at_vote && w_vote;
    w_ferr = rxclk_en && (r_state == c_STOP) && w_at_vote && !w_vote;
  end

  // The detecting tick is tick 0 of the start bit, so the counter leaves IDLE at 1.
  always_comb begin
    w_tc_next = r_tc;
    if (rxclk_en) begin
      if (r_state == c_IDLE)
        w_tc_next = w_rx_s ? '0 : CNT_WIDTH'(1);
      else if ((r_state == c_BREAK) || w_at_last || (w_state_next != r_state))
        w_tc_next = '0;
      else
        w_tc_next = r_tc + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc      <= '0;
      r_samp    <= 2'b11;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_ucode   <= 8'h00;
      r_uvalid  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_uvalid <= w_load;
      r_ferr   <= w_ferr;
      if (w_load) r_ucode <= r_shift;
      r_tc <= w_tc_next;
      if (rxclk_en) begin
        if (r_tc == c_TC_S0) r_samp[0] <= w_rx_s;
        if (r_tc == c_TC_S1) r_samp[1] <= w_rx_s;
        if (r_state != c_DATA)  r_bit_idx <= 3'd0;
        else if (w_at_last)     r_bit_idx <= r_bit_idx + 3'd1;
        if ((r_state == c_DATA) && w_at_vote) r_shift[r_bit_idx] <= w_vote;
      end
    end
  end

  assign ucode     = r_ucode;
  assign uvalid    = r_uvalid;
  assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_uart_rx_oversample
// Brief   : Randomised frame stimulus against a time-majority decode model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversample;

  localparam int M        = 8;
  localparam int TICK     = 45;
  localparam int BIT_CLKS = M * TICK;

  logic       clk = 1'b0;
  logic       rst, rxclk_en, rx;
  logic [7:0] ucode;
  logic       uvalid, frame_err, busy;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] got_q[$];
  longint     got_t[$];
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         n_ferr = 0, n_overlap = 0, n_long = 0, tick_no = 0;
  longint     cyc = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx_oversample #(.SAMPLE_MULTIPLIER(M), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rxclk_en(rxclk_en), .rx(rx),
    .ucode(ucode), .uvalid(uvalid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    rxclk_en = 1'b0;
    forever begin
      repeat (TICK - 1) @(negedge clk);
      rxclk_en = 1'b1;
      @(negedge clk);
      rxclk_en = 1'b0;
    end
  end

  always @(posedge clk) if (rxclk_en) tick_no++;

  always @(negedge clk) begin
    cyc++;
    if (uvalid) begin got_q.push_back(ucode); got_t.push_back(cyc); end
    if (frame_err) n_ferr++;
    if (uvalid && frame_err) n_overlap++;
    if ((uvalid && prev_v) || (frame_err && prev_f)) n_long++;
    prev_v = uvalid;
    prev_f = frame_err;
  end

  // Model: a bit decodes to whichever level the line holds for most of the bit period.
  task automatic drive_bit(input logic v, input int goff, input int glen, output logic mv);
    int high;
    rx = v;
    if (glen == 0) begin
      repeat (BIT_CLKS) @(negedge clk);
    end else begin
      repeat (goff) @(negedge clk);
      rx = ~v;
      repeat (glen) @(negedge clk);
      rx = v;
      repeat (BIT_CLKS - goff - glen) @(negedge clk);
    end
    high = v ? (BIT_CLKS - glen) : glen;
    mv = (2 * high > BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int gmode);
    logic mv, ms;
    logic [7:0] mb;
    int go, gl;
    drive_bit(1'b0, 0, 0, mv);
    for (int i = 0; i < 8; i++) begin
      go = 0; gl = 0;
      if (gmode == 1) begin go = 4 * TICK; gl = TICK; end
      else if (gmode == 2) begin go = $urandom_range(5 * TICK, 2 * TICK); gl = 40; end
      drive_bit(d[i], go, gl, mv);
      mb[i] = mv;
    end
    drive_bit(stop_v, 0, 0, ms);
    if (ms) exp_q.push_back(mb);
    else    exp_ferr++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (ucode !== 8'h00) begin errors++; $display("FAIL reset_ucode: got %h expected 00", ucode); end
    vectors++; if (uvalid !== 1'b0) begin errors++; $display("FAIL reset_uvalid: got %b expected 0", uvalid); end
    vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int f0, e0;
    f0 = n_ferr; e0 = exp_ferr;
    repeat ($urandom_range(300, 50)) @(negedge clk);
    fork
      send_frame(8'h41, 1'b1, 0);
      begin
        repeat (5 * BIT_CLKS) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy); end
      end
    join
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    vectors++; if (n_ferr - f0 != exp_ferr - e0) begin errors++; $display("FAIL basic_ferr: got %0d expected %0d", n_ferr - f0, exp_ferr - e0); end
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_glitch_start();
    int f0, t0;
    f0 = n_ferr;
    t0 = tick_no;
    for (int k = 0; k < 200 && tick_no == t0; k++) @(negedge clk);
    rx = 1'b0;
    repeat (2 * TICK) @(negedge clk);
    rx = 1'b1;
    t0 = tick_no;
    for (int k = 0; k < 1000 && tick_no < t0 + 4; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    vectors++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_uvalid: got %0d pulses expected 0", got_q.size()); end
    vectors++; if (n_ferr != f0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h5A, 1'b1, 0);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_next_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_stop_error();
    int f0, e0;
    f0 = n_ferr; e0 = exp_ferr;
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h55, 1'b0, 0);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (n_ferr - f0 != exp_ferr - e0) begin errors++; $display("FAIL stop_ferr_count: got %0d expected %0d", n_ferr - f0, exp_ferr - e0); end
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stop_uvalid: got %0d expected %0d", got_q.size(), exp_q.size()); end
    vectors++; if (ucode !== last_good) begin errors++; $display("FAIL stop_ucode_held: got %h expected %h", ucode, last_good); end
    got_q.delete(); got_t.delete(); exp_q.delete();
    send_frame(8'hA5, 1'b1, 0);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stop_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stop_next_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_majority();
    repeat ($urandom_range(200, 20)) @(negedge clk);
    send_frame(8'h00, 1'b1, 1);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL majority_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL majority_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    longint dt;
    repeat ($urandom_range(200, 20)) @(negedge clk);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    if (got_t.size() == 2) begin
      dt = got_t[1] - got_t[0];
      vectors++;
      if (dt < 10 * BIT_CLKS - TICK || dt > 10 * BIT_CLKS + TICK) begin
        errors++; $display("FAIL b2b_spacing: got %0d clk expected %0d +/- %0d", dt, 10 * BIT_CLKS, TICK);
      end
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    int f0;
    d = 8'h33;
    f0 = n_ferr;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin rx = d[i]; repeat (BIT_CLKS) @(negedge clk); end
    rx = d[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (ucode !== 8'h00) begin errors++; $display("FAIL arst_ucode: got %h expected 00", ucode); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    vectors++; if (uvalid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL arst_pulses: got %b%b expected 00", uvalid, frame_err); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (2 * BIT_CLKS) @(negedge clk);
    vectors++; if (got_q.size() != 0 || n_ferr != f0) begin errors++; $display("FAIL arst_no_pulse: got %0d uvalid %0d frame_err expected 0 0", got_q.size(), n_ferr - f0); end
    got_q.delete(); got_t.delete();
    send_frame(8'hC3, 1'b1, 0);
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL arst_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL arst_next_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_random_frames();
    int f0, e0;
    logic [7:0] d;
    logic stop_v;
    f0 = n_ferr; e0 = exp_ferr;
    for (int n = 0; n < 4; n++) begin
      rx = 1'b1;
      repeat ($urandom_range(3 * TICK, 2 * TICK)) @(negedge clk);
      d = 8'($urandom);
      stop_v = ($urandom_range(3, 0) != 0);
      send_frame(d, stop_v, int'($urandom_range(2, 0)));
    end
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    vectors++; if (n_ferr - f0 != exp_ferr - e0) begin errors++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr - f0, exp_ferr - e0); end
    vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte: got %h expected %h", got_q[i], exp_q[i]); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  task automatic test_pulse_shape();
    vectors++; if (n_overlap != 0) begin errors++; $display("FAIL pulse_overlap: got %0d expected 0", n_overlap); end
    vectors++; if (n_long != 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", n_long); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch_start();
    test_stop_error();
    test_majority();
    test_back_to_back();
    test_async_reset();
    test_random_frames();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
